// File: rtl/sram_video_looper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sram_video_looper                                              |
// | Purpose : Slot-based record/playback engine between an RPi video source  |
// |           and an asynchronous SRAM, with loop window and address jump.   |
// | Option  : VSYNC_RESTART_EN - a falling v_sync_in restarts the address at |
// |           loop_start on the next slot boundary.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sram_video_looper #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int DIV_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] loop_start,
  input  logic [ADDR_W-1:0] loop_end,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] io,
  output logic              cs_n,
  output logic              we_n,
  output logic              oe_n,
  output logic              h_sync,
  output logic              v_sync,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid
);

  localparam int                c_SLOT = 2**DIV_LOG2;
  localparam logic [DIV_LOG2-1:0] c_LAST = {DIV_LOG2{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIV_LOG2-1:0] r_cnt;
  logic                w_tick;
  logic                w_adv;
  logic                w_drive;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_jpend;
  logic [ADDR_W-1:0]   r_jaddr;
  logic                w_jump_hit;
  logic [ADDR_W-1:0]   w_jump_tgt;
  logic                w_restart;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [c_SLOT-1:0]   r_hs;
  logic [c_SLOT-1:0]   r_vs;

  // Slot boundary is the last phase; address only advances after an active
  // slot so the first slot after IDLE uses address 0.
  assign w_tick = (r_cnt == c_LAST);
  assign w_adv  = w_tick && (r_state != IDLE);

  // Free-running slot phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and SRAM strobes; write strobe avoids the first and last phase
  always_comb begin
    w_state_nxt = r_state;
    cs_n        = 1'b1;
    we_n        = 1'b1;
    oe_n        = 1'b1;
    w_drive     = 1'b0;
    if (w_tick) w_state_nxt = rec ? WRITE : READ;
    case (r_state)
      WRITE: begin
        cs_n    = 1'b0;
        w_drive = 1'b1;
        if ((r_cnt != '0) && (r_cnt != c_LAST)) we_n = 1'b0;
      end
      READ: begin
        cs_n = 1'b0;
        oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign io = w_drive ? r_wdata : {DATA_W{1'bz}};

  // Jump request capture; a live pulse on the boundary is consumed directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jpend <= 1'b0;
      r_jaddr <= '0;
    end else begin
      if (jump)       r_jaddr <= jump_addr;
      if (w_adv)      r_jpend <= 1'b0;
      else if (jump)  r_jpend <= 1'b1;
    end
  end

  assign w_jump_hit = jump || r_jpend;
  assign w_jump_tgt = jump ? jump_addr : r_jaddr;

`ifdef VSYNC_RESTART_EN
  logic [2:0] r_vs_sync;
  logic       r_restart;

  // Synchronise v_sync_in and hold a restart request until a boundary uses it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_sync <= '1;
      r_restart <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[1:0], v_sync_in};
      if (r_vs_sync[2] && !r_vs_sync[1])  r_restart <= 1'b1;
      else if (w_adv && !w_jump_hit)      r_restart <= 1'b0;
    end
  end

  assign w_restart = r_restart;
`else
  assign w_restart = 1'b0;
`endif

  // Next address: jump, then restart, then loop wrap, then increment
  always_comb begin
    w_addr_nxt = addr + 1'b1;
    if (w_jump_hit)
      w_addr_nxt = w_jump_tgt;
    else if (w_restart)
      w_addr_nxt = loop_start;
    else if ((addr == loop_end) && (loop_start <= loop_end))
      w_addr_nxt = loop_start;
  end

  // Address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     addr <= '0;
    else if (w_adv) addr <= w_addr_nxt;
  end

  // Write data latch at slot start, and pixel output at slot end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata   <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (w_tick) r_wdata <= pix_in;
      pix_valid <= w_adv;
      if (w_adv) pix_out <= (r_state == WRITE) ? r_wdata : io;
    end
  end

  // Sync delay line, one slot long, keeps syncs aligned with pix_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs <= '1;
      r_vs <= '1;
    end else begin
      r_hs <= {r_hs[c_SLOT-2:0], h_sync_in};
      r_vs <= {r_vs[c_SLOT-2:0], v_sync_in};
    end
  end

  assign h_sync = r_hs[c_SLOT-1];
  assign v_sync = r_vs[c_SLOT-1];

endmodule
`default_nettype wire

// File: tb/tb_sram_video_looper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sram_video_looper                                           |
// | Purpose : Scoreboard bench for sram_video_looper with an SRAM model.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sram_video_looper;

  typedef struct packed {
    logic [7:0]  pix;
    logic [17:0] nxt;
  } exp_t;

  typedef struct packed {
    int          jph;
    logic [17:0] ja;
    logic [7:0]  pix;
    logic [17:0] nxt;
  } vec_t;

`ifdef VSYNC_RESTART_EN
  localparam logic [17:0] c_E1 = 18'd8;
  localparam logic [7:0]  c_D1 = 8'h52;
`else
  localparam logic [17:0] c_E1 = 18'h15;
  localparam logic [7:0]  c_D1 = 8'h4F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec = 1'b1;
  logic [7:0]  pix_in = 8'hA5;
  logic        h_sync_in = 1'b1;
  logic        v_sync_in = 1'b1;
  logic        jump = 1'b0;
  logic [17:0] jump_addr = '0;
  logic [17:0] loop_start = '0;
  logic [17:0] loop_end = 18'h3FFFF;
  logic [17:0] addr;
  wire  [7:0]  io;
  logic        cs_n, we_n, oe_n, h_sync, v_sync, pix_valid;
  logic [7:0]  pix_out;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] mem [0:1023];

  sram_video_looper dut (
    .clk(clk), .rst_n(rst_n), .rec(rec), .pix_in(pix_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .jump(jump),
    .jump_addr(jump_addr), .loop_start(loop_start), .loop_end(loop_end),
    .addr(addr), .io(io), .cs_n(cs_n), .we_n(we_n), .oe_n(oe_n),
    .h_sync(h_sync), .v_sync(v_sync), .pix_out(pix_out), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  // SRAM model: preset pattern on reset, level-sensitive write strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (!cs_n && !we_n) begin
      mem[addr[9:0]] <= io;
    end
  end

  assign io = (!cs_n && !oe_n && we_n) ? mem[addr[9:0]] : 8'bz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output pixel pops one expected word/address pair
  always @(negedge clk) begin
    if (rst_n && pix_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pix_valid: got pix %0h addr %0h expected none", pix_out, addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pix_out", 32'(pix_out), 32'(e.pix));
        chk("addr_next", 32'(addr), 32'(e.nxt));
      end
    end
  end

  task automatic run_slot(input int jph, input logic [17:0] ja, input int vph, output int lows);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      jump = (i == jph);
      if (i == jph) jump_addr = ja;
      if (i == vph) v_sync_in = 1'b0;
      if (!we_n) lows++;
      @(negedge clk);
    end
    jump = 1'b0;
  endtask

  vec_t vecs [0:10];

  initial begin
    int lows;
    int idle;
    vecs[0]  = '{-1, 18'h0,     8'h58, 18'h3};
    vecs[1]  = '{-1, 18'h0,     8'h59, 18'h4};
    vecs[2]  = '{-1, 18'h0,     8'h5E, 18'h5};
    vecs[3]  = '{-1, 18'h0,     8'h5F, 18'h6};
    vecs[4]  = '{-1, 18'h0,     8'h5C, 18'h4};
    vecs[5]  = '{-1, 18'h0,     8'h5E, 18'h5};
    vecs[6]  = '{2,  18'h100,   8'h5F, 18'h100};
    vecs[7]  = '{-1, 18'h0,     8'h5A, 18'h101};
    vecs[8]  = '{7,  18'h3FFFF, 8'h5B, 18'h3FFFF};
    vecs[9]  = '{-1, 18'h0,     8'hA5, 18'h0};
    vecs[10] = '{3,  18'h14,    8'hA5, 18'h14};

    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h1);
    chk("rst_we_n", 32'(we_n), 32'h1);
    chk("rst_oe_n", 32'(oe_n), 32'h1);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_syncs", 32'({h_sync, v_sync}), 32'h3);

    // One IDLE slot after release
    rst_n = 1'b1;
    idle = 1;
    @(negedge clk);
    while (cs_n && idle < 40) begin
      idle++;
      @(negedge clk);
    end
    chk("idle_len", 32'(idle), 32'd8);

    // Record two words
    chk("wr_io", 32'(io), 32'hA5);
    chk("wr_oe_n", 32'(oe_n), 32'h1);
    exp_q.push_back('{8'hA5, 18'h1});
    pix_in = 8'h3C;
    run_slot(-1, 18'h0, -1, lows);
    chk("we_low_slot0", 32'(lows), 32'd6);
    exp_q.push_back('{8'h3C, 18'h2});
    rec = 1'b0;
    loop_start = 18'd4;
    loop_end   = 18'd6;
    run_slot(-1, 18'h0, -1, lows);
    chk("we_low_slot1", 32'(lows), 32'd6);
    chk("sram0", 32'(mem[0]), 32'hA5);
    chk("sram1", 32'(mem[1]), 32'h3C);

    // Playback: loop window, jump mid-slot, jump on boundary, wrap
    for (int k = 0; k < 11; k++) begin
      if (k == 8) begin
        loop_start = 18'd9;
        loop_end   = 18'd2;
      end
      if (k == 10) loop_start = 18'd8;
      exp_q.push_back('{vecs[k].pix, vecs[k].nxt});
      run_slot(vecs[k].jph, vecs[k].ja, -1, lows);
      chk("rd_we_low", 32'(lows), 32'd0);
    end

    // v_sync falling edge at address 0x14
    exp_q.push_back('{8'h4E, c_E1});
    run_slot(-1, 18'h0, 1, lows);
    exp_q.push_back('{c_D1, c_E1 + 18'd1});
    rec = 1'b1;
    run_slot(-1, 18'h0, -1, lows);

    // Write slot with h_sync delay check
    exp_q.push_back('{8'h3C, c_E1 + 18'd2});
    chk("v_sync_delayed", 32'(v_sync), 32'h0);
    h_sync_in = 1'b0;
    repeat (7) @(negedge clk);
    chk("h_sync_7clk", 32'(h_sync), 32'h1);
    @(negedge clk);
    chk("h_sync_8clk", 32'(h_sync), 32'h0);

    // Reset in the middle of a write strobe
    repeat (3) @(negedge clk);
    chk("mid_we_n", 32'(we_n), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we_n", 32'(we_n), 32'h1);
    chk("async_cs_n", 32'(cs_n), 32'h1);
    chk("async_oe_n", 32'(oe_n), 32'h1);
    chk("async_addr", 32'(addr), 32'h0);
    chk("async_pix_out", 32'(pix_out), 32'h0);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
`default_nettype wire
